bsg_manycore_local_port_mux: RTL and testbench

Parametrised local-port adapter between one buffered mesh router's processor port and `num_ep_p` local endpoints (cores, accelerators, memory slaves) in a next-generation manycore tile. It generalises the one-processor-per-tile arrangement:
- **Egress:** round-robin arbitration of endpoint packets into a registered output stage toward the router.
- **Ingress:** demultiplexing of router packets by an endpoint-select field into per-endpoint FIFOs.
- **Errors:** sticky error flag for misaddressed packets.

---
 rtl/bsg_manycore_local_mux_pkg.sv | 15 +
 rtl/bsg_fifo_1r1w_small.sv | 64 ++++++
 rtl/bsg_manycore_local_mux_rr_arb.sv | 47 ++++
 rtl/bsg_manycore_local_port_mux.sv | 139 +++++++++++++
 tb/tb_bsg_manycore_local_port_mux.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bsg_manycore_local_mux_pkg.sv
// Shared constants and helpers for the manycore local-port mux.
package bsg_manycore_local_mux_pkg;

  // Largest supported number of local endpoints.
  localparam int max_ep_gp = 8;

  // Width of the optional per-endpoint statistics counters.
  localparam int stats_width_gp = 16;

  // Ceiling log2 that never returns zero, so single-entry fields remain one bit wide.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read one-write FIFO.
// ready_o depends only on the stored occupancy, never on yumi_i.
// The head entry is presented combinationally on data_o.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_width_lp = (els_p <= 2) ? 1 : $clog2(els_p);
  localparam int cnt_width_lp = $clog2(els_p + 1);
  localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);
  localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(els_p);

  logic [width_p-1:0]      mem_reg [els_p];
  logic [ptr_width_lp-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ptr_width_lp-1:0] rd_ptr_reg, rd_ptr_next;
  logic [cnt_width_lp-1:0] count_reg, count_next;
  logic                    enq, deq;

  assign ready_o = (count_reg != full_cnt_lp);
  assign v_o     = (count_reg != '0);
  assign data_o  = mem_reg[rd_ptr_reg];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  // Pointer wrap and occupancy update.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (enq) wr_ptr_next = (wr_ptr_reg == last_ptr_lp) ? '0 : wr_ptr_reg + 1'b1;
    if (deq) rd_ptr_next = (rd_ptr_reg == last_ptr_lp) ? '0 : rd_ptr_reg + 1'b1;
    if (enq && !deq) count_next = count_reg + 1'b1;
    else if (!enq && deq) count_next = count_reg - 1'b1;
  end

  // Storage write; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk_i) begin
    if (enq) mem_reg[wr_ptr_reg] <= data_i;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: rtl/bsg_manycore_local_mux_rr_arb.sv
// Round-robin arbiter with a one-hot grant.
// The pointer names the highest-priority requester.
// After a grant to k, the pointer moves to the slot after k.
module bsg_manycore_local_mux_rr_arb
  import bsg_manycore_local_mux_pkg::*;
#(
  parameter int num_ep_p = 2
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                en_i,
  input  logic [num_ep_p-1:0] req_i,
  output logic [num_ep_p-1:0] grant_o
);

  localparam int ptr_width_lp = safe_clog2(num_ep_p);

  logic [ptr_width_lp-1:0] ptr_reg, ptr_next;
  logic                    found;
  int                      idx;

  // Scan requesters starting at the pointer and grant the first one found.
  always_comb begin
    grant_o  = '0;
    ptr_next = ptr_reg;
    found    = 1'b0;
    idx      = 0;
    if (en_i) begin
      for (int off = 0; off < num_ep_p; off++) begin
        idx = int'(ptr_reg) + off;
        if (idx >= num_ep_p) idx = idx - num_ep_p;
        if (!found && req_i[idx]) begin
          found        = 1'b1;
          grant_o[idx] = 1'b1;
          ptr_next     = (idx + 1 == num_ep_p) ? '0 : ptr_width_lp'(idx + 1);
        end
      end
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) ptr_reg <= '0;
    else            ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/bsg_manycore_local_port_mux.sv
// Local-port adapter between one router processor port and num_ep_p endpoints.
// Egress: round-robin into a single output register.
// Ingress: demultiplexed by the select field into per-endpoint FIFOs.
// Define BSG_MANYCORE_LOCAL_MUX_STATS_EN to add saturating per-endpoint tx/rx counters.
module bsg_manycore_local_port_mux
  import bsg_manycore_local_mux_pkg::*;
#(
  parameter int packet_width_p  = 32,
  parameter int num_ep_p        = 2,
  parameter int fifo_els_p      = 2,
  parameter int ep_sel_offset_p = 0,
  parameter int ep_sel_width_lp = safe_clog2(num_ep_p)
) (
  input  logic                                     clk_i,
  input  logic                                     reset_n_i,
  input  logic                                     rtr_v_i,
  input  logic [packet_width_p-1:0]                rtr_data_i,
  output logic                                     rtr_ready_o,
  output logic                                     rtr_v_o,
  output logic [packet_width_p-1:0]                rtr_data_o,
  input  logic                                     rtr_ready_i,
  input  logic [num_ep_p-1:0]                      ep_v_i,
  input  logic [num_ep_p-1:0][packet_width_p-1:0]  ep_data_i,
  output logic [num_ep_p-1:0]                      ep_ready_o,
  output logic [num_ep_p-1:0]                      ep_v_o,
  output logic [num_ep_p-1:0][packet_width_p-1:0]  ep_data_o,
  input  logic [num_ep_p-1:0]                      ep_yumi_i,
`ifdef BSG_MANYCORE_LOCAL_MUX_STATS_EN
  output logic [num_ep_p-1:0][stats_width_gp-1:0]  ep_tx_count_o,
  output logic [num_ep_p-1:0][stats_width_gp-1:0]  ep_rx_count_o,
`endif
  output logic                                     err_o
);

  // ---------------- Egress ----------------
  logic                      out_v_reg;
  logic [packet_width_p-1:0] out_data_reg;
  logic [packet_width_p-1:0] grant_data;
  logic                      load_ok;

  assign load_ok    = !out_v_reg || rtr_ready_i;
  assign rtr_v_o    = out_v_reg;
  assign rtr_data_o = out_data_reg;

  bsg_manycore_local_mux_rr_arb #(.num_ep_p(num_ep_p)) arb (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (load_ok),
    .req_i     (ep_v_i),
    .grant_o   (ep_ready_o)
  );

  // One-hot grant selects the packet loaded into the output register.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < num_ep_p; i++) begin
      if (ep_ready_o[i]) grant_data = grant_data | ep_data_i[i];
    end
  end

  // Output register: load on grant, otherwise drain when the router accepts.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      out_v_reg    <= 1'b0;
      out_data_reg <= '0;
    end else if (|ep_ready_o) begin
      out_v_reg    <= 1'b1;
      out_data_reg <= grant_data;
    end else if (rtr_ready_i) begin
      out_v_reg    <= 1'b0;
    end
  end

  // ---------------- Ingress ----------------
  logic [num_ep_p-1:0] fifo_ready;
  logic [num_ep_p-1:0] enq_v;
  logic                sel_hit;
  logic                sel_ready;
  logic                fifo_reset;
  logic                err_reg;

  assign fifo_reset  = ~reset_n_i;
  assign rtr_ready_o = sel_hit ? sel_ready : 1'b1;
  assign err_o       = err_reg;

  if (num_ep_p == 1) begin : g_single
    assign sel_hit   = 1'b1;
    assign sel_ready = fifo_ready[0];
    assign enq_v[0]  = rtr_v_i & fifo_ready[0];
  end else begin : g_multi
    localparam logic [ep_sel_width_lp:0] num_ep_lp = (ep_sel_width_lp + 1)'(num_ep_p);
    logic [ep_sel_width_lp-1:0] sel;
    assign sel       = rtr_data_i[ep_sel_offset_p +: ep_sel_width_lp];
    assign sel_hit   = ({1'b0, sel} < num_ep_lp);
    assign sel_ready = sel_hit ? fifo_ready[sel] : 1'b0;
    for (genvar gi = 0; gi < num_ep_p; gi++) begin : g_dec
      assign enq_v[gi] = rtr_v_i & sel_hit & (sel == ep_sel_width_lp'(gi)) & fifo_ready[gi];
    end
  end

  for (genvar gi = 0; gi < num_ep_p; gi++) begin : g_fifo
    bsg_fifo_1r1w_small #(.width_p(packet_width_p), .els_p(fifo_els_p)) fifo (
      .clk_i   (clk_i),
      .reset_i (fifo_reset),
      .v_i     (enq_v[gi]),
      .ready_o (fifo_ready[gi]),
      .data_i  (rtr_data_i),
      .v_o     (ep_v_o[gi]),
      .data_o  (ep_data_o[gi]),
      .yumi_i  (ep_yumi_i[gi])
    );
  end

  // Sticky flag for packets whose select names no endpoint; they are accepted and dropped.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) err_reg <= 1'b0;
    else if (rtr_v_i && !sel_hit) err_reg <= 1'b1;
  end

`ifdef BSG_MANYCORE_LOCAL_MUX_STATS_EN
  // ---------------- Statistics ----------------
  for (genvar gi = 0; gi < num_ep_p; gi++) begin : g_stats
    logic [stats_width_gp-1:0] tx_cnt_reg, rx_cnt_reg;
    assign ep_tx_count_o[gi] = tx_cnt_reg;
    assign ep_rx_count_o[gi] = rx_cnt_reg;
    // Saturating grant and enqueue counters.
    always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
        tx_cnt_reg <= '0;
        rx_cnt_reg <= '0;
      end else begin
        if (ep_ready_o[gi] && tx_cnt_reg != '1) tx_cnt_reg <= tx_cnt_reg + 1'b1;
        if (enq_v[gi]      && rx_cnt_reg != '1) rx_cnt_reg <= rx_cnt_reg + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bsg_manycore_local_port_mux.sv
// Directed testbench for bsg_manycore_local_port_mux (3 endpoints, 16-bit packets, 2-deep FIFOs).
// Stats counters are exercised when BSG_MANYCORE_LOCAL_MUX_STATS_EN is defined.
module tb_bsg_manycore_local_port_mux;

  localparam int PW = 16;
  localparam int N  = 3;

  logic              clk;
  logic              reset_n;
  logic              rtr_v_i;
  logic [PW-1:0]     rtr_data_i;
  logic              rtr_ready_o;
  logic              rtr_v_o;
  logic [PW-1:0]     rtr_data_o;
  logic              rtr_ready_i;
  logic [N-1:0]      ep_v_i;
  logic [N-1:0][PW-1:0] ep_data_i;
  logic [N-1:0]      ep_ready_o;
  logic [N-1:0]      ep_v_o;
  logic [N-1:0][PW-1:0] ep_data_o;
  logic [N-1:0]      ep_yumi_i;
  logic              err_o;
`ifdef BSG_MANYCORE_LOCAL_MUX_STATS_EN
  logic [N-1:0][15:0] ep_tx_count_o;
  logic [N-1:0][15:0] ep_rx_count_o;
`endif

  int vectors;
  int miscompares;

  bsg_manycore_local_port_mux #(
    .packet_width_p(PW), .num_ep_p(N), .fifo_els_p(2), .ep_sel_offset_p(0)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .rtr_v_i     (rtr_v_i),
    .rtr_data_i  (rtr_data_i),
    .rtr_ready_o (rtr_ready_o),
    .rtr_v_o     (rtr_v_o),
    .rtr_data_o  (rtr_data_o),
    .rtr_ready_i (rtr_ready_i),
    .ep_v_i      (ep_v_i),
    .ep_data_i   (ep_data_i),
    .ep_ready_o  (ep_ready_o),
    .ep_v_o      (ep_v_o),
    .ep_data_o   (ep_data_o),
    .ep_yumi_i   (ep_yumi_i),
`ifdef BSG_MANYCORE_LOCAL_MUX_STATS_EN
    .ep_tx_count_o (ep_tx_count_o),
    .ep_rx_count_o (ep_rx_count_o),
`endif
    .err_o       (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required: completion");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    reset_n = 1'b0; rtr_v_i = 1'b0; rtr_data_i = '0; rtr_ready_i = 1'b0;
    ep_v_i = '0; ep_data_i = '0; ep_yumi_i = '0;
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (rtr_v_o !== 1'b0) begin miscompares++; $display("FAIL reset_rtr_v: got %b expected 0", rtr_v_o); end
    vectors++; if (ep_v_o !== 3'b000) begin miscompares++; $display("FAIL reset_ep_v: got %b expected 000", ep_v_o); end
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", err_o); end
    vectors++; if (rtr_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_rtr_ready: got %b expected 1", rtr_ready_o); end
    vectors++; if (ep_ready_o !== 3'b000) begin miscompares++; $display("FAIL reset_ep_ready: got %b expected 000", ep_ready_o); end
    $display("reset: rtr_v=%b ep_v=%b err=%b rtr_ready=%b", rtr_v_o, ep_v_o, err_o, rtr_ready_o);
  endtask

  task automatic test_round_robin;
    logic [N-1:0]  exp_ready;
    logic [PW-1:0] exp_data;
    @(negedge clk);
    reset_n = 1'b1; rtr_ready_i = 1'b1; ep_v_i = 3'b011;
    ep_data_i[0] = 16'h00A0; ep_data_i[1] = 16'h00B1;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp_ready = (i % 2 == 0) ? 3'b001 : 3'b010;
      vectors++; if (ep_ready_o !== exp_ready) begin miscompares++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, ep_ready_o, exp_ready); end
      vectors++; if (rtr_v_o !== (i != 0)) begin miscompares++; $display("FAIL rr_rtr_v[%0d]: got %b expected %b", i, rtr_v_o, (i != 0)); end
      if (i > 0) begin
        exp_data = ((i - 1) % 2 == 0) ? 16'h00A0 : 16'h00B1;
        vectors++; if (rtr_data_o !== exp_data) begin miscompares++; $display("FAIL rr_data[%0d]: got %h expected %h", i, rtr_data_o, exp_data); end
      end
      $display("rr cycle %0d: grant=%b rtr_v=%b rtr_data=%h", i, ep_ready_o, rtr_v_o, rtr_data_o);
      @(negedge clk);
    end
    ep_v_i = '0;
    #1;
    vectors++; if (rtr_data_o !== 16'h00B1) begin miscompares++; $display("FAIL rr_last_data: got %h expected 00b1", rtr_data_o); end
    vectors++; if (ep_ready_o !== 3'b000) begin miscompares++; $display("FAIL rr_idle_grant: got %b expected 000", ep_ready_o); end
    @(negedge clk); #1;
    vectors++; if (rtr_v_o !== 1'b0) begin miscompares++; $display("FAIL rr_drain: got %b expected 0", rtr_v_o); end
  endtask

  task automatic test_backpressure;
    rtr_ready_i = 1'b0; ep_v_i = 3'b001; ep_data_i[0] = 16'h0A5A;
    #1;
    vectors++; if (ep_ready_o !== 3'b001) begin miscompares++; $display("FAIL bp_first_grant: got %b expected 001", ep_ready_o); end
    @(negedge clk);
    ep_data_i[0] = 16'h0B5B;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++; if (rtr_v_o !== 1'b1) begin miscompares++; $display("FAIL bp_hold_v[%0d]: got %b expected 1", i, rtr_v_o); end
      vectors++; if (rtr_data_o !== 16'h0A5A) begin miscompares++; $display("FAIL bp_hold_data[%0d]: got %h expected 0a5a", i, rtr_data_o); end
      vectors++; if (ep_ready_o !== 3'b000) begin miscompares++; $display("FAIL bp_hold_grant[%0d]: got %b expected 000", i, ep_ready_o); end
      $display("bp hold %0d: rtr_v=%b rtr_data=%h grant=%b", i, rtr_v_o, rtr_data_o, ep_ready_o);
      @(negedge clk);
    end
    rtr_ready_i = 1'b1;
    #1;
    vectors++; if (ep_ready_o !== 3'b001) begin miscompares++; $display("FAIL bp_reload_grant: got %b expected 001", ep_ready_o); end
    @(negedge clk);
    ep_v_i = '0;
    #1;
    vectors++; if (rtr_v_o !== 1'b1) begin miscompares++; $display("FAIL bp_next_v: got %b expected 1", rtr_v_o); end
    vectors++; if (rtr_data_o !== 16'h0B5B) begin miscompares++; $display("FAIL bp_next_data: got %h expected 0b5b", rtr_data_o); end
    $display("bp release: rtr_data=%h", rtr_data_o);
    @(negedge clk);
  endtask

  task automatic test_fifo_full;
    rtr_v_i = 1'b1; rtr_data_i = 16'h1001;
    #1;
    vectors++; if (rtr_ready_o !== 1'b1) begin miscompares++; $display("FAIL ff_ready_p1: got %b expected 1", rtr_ready_o); end
    @(negedge clk);
    rtr_data_i = 16'h2001;
    #1;
    vectors++; if (ep_v_o !== 3'b010) begin miscompares++; $display("FAIL ff_ep_v_p1: got %b expected 010", ep_v_o); end
    vectors++; if (ep_data_o[1] !== 16'h1001) begin miscompares++; $display("FAIL ff_head_p1: got %h expected 1001", ep_data_o[1]); end
    vectors++; if (rtr_ready_o !== 1'b1) begin miscompares++; $display("FAIL ff_ready_p2: got %b expected 1", rtr_ready_o); end
    @(negedge clk);
    rtr_data_i = 16'h3001;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++; if (rtr_ready_o !== 1'b0) begin miscompares++; $display("FAIL ff_ready_full[%0d]: got %b expected 0", i, rtr_ready_o); end
      $display("fifo full %0d: rtr_ready=%b ep_v=%b", i, rtr_ready_o, ep_v_o);
      @(negedge clk);
    end
    vectors++; if (ep_v_o[0] !== 1'b0) begin miscompares++; $display("FAIL ff_ep0_blocked: got %b expected 0", ep_v_o[0]); end
    ep_yumi_i = 3'b010;
    #1;
    vectors++; if (rtr_ready_o !== 1'b0) begin miscompares++; $display("FAIL ff_ready_yumi: got %b expected 0", rtr_ready_o); end
    @(negedge clk);
    ep_yumi_i = '0;
    #1;
    vectors++; if (ep_data_o[1] !== 16'h2001) begin miscompares++; $display("FAIL ff_head_p2: got %h expected 2001", ep_data_o[1]); end
    vectors++; if (rtr_ready_o !== 1'b1) begin miscompares++; $display("FAIL ff_ready_after_yumi: got %b expected 1", rtr_ready_o); end
    @(negedge clk);
    rtr_data_i = 16'h4000;
    #1;
    vectors++; if (rtr_ready_o !== 1'b1) begin miscompares++; $display("FAIL ff_ready_ep0: got %b expected 1", rtr_ready_o); end
    @(negedge clk);
    rtr_v_i = 1'b0;
    #1;
    vectors++; if (ep_v_o !== 3'b011) begin miscompares++; $display("FAIL ff_ep_v_both: got %b expected 011", ep_v_o); end
    vectors++; if (ep_data_o[0] !== 16'h4000) begin miscompares++; $display("FAIL ff_head_ep0: got %h expected 4000", ep_data_o[0]); end
    ep_yumi_i = 3'b011;
    @(negedge clk);
    #1;
    vectors++; if (ep_data_o[1] !== 16'h3001) begin miscompares++; $display("FAIL ff_head_p3: got %h expected 3001", ep_data_o[1]); end
    vectors++; if (ep_v_o !== 3'b010) begin miscompares++; $display("FAIL ff_ep_v_last: got %b expected 010", ep_v_o); end
    ep_yumi_i = 3'b010;
    @(negedge clk);
    ep_yumi_i = '0;
    #1;
    vectors++; if (ep_v_o !== 3'b000) begin miscompares++; $display("FAIL ff_empty: got %b expected 000", ep_v_o); end
    $display("fifo drained: ep_v=%b", ep_v_o);
  endtask

  task automatic test_misaddress;
    rtr_v_i = 1'b1; rtr_data_i = 16'h5553;
    #1;
    vectors++; if (rtr_ready_o !== 1'b1) begin miscompares++; $display("FAIL err_ready: got %b expected 1", rtr_ready_o); end
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL err_before: got %b expected 0", err_o); end
    @(negedge clk);
    rtr_v_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL err_sticky[%0d]: got %b expected 1", i, err_o); end
      vectors++; if (ep_v_o !== 3'b000) begin miscompares++; $display("FAIL err_no_enq[%0d]: got %b expected 000", i, ep_v_o); end
      $display("misaddress %0d: err=%b ep_v=%b", i, err_o, ep_v_o);
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    rtr_ready_i = 1'b0; ep_v_i = 3'b001; ep_data_i[0] = 16'h0C0C;
    rtr_v_i = 1'b1; rtr_data_i = 16'h6002;
    @(negedge clk);
    ep_v_i = '0; rtr_data_i = 16'h7002;
    @(negedge clk);
    rtr_v_i = 1'b0;
    #1;
    vectors++; if (ep_v_o !== 3'b100) begin miscompares++; $display("FAIL mid_pre_ep_v: got %b expected 100", ep_v_o); end
    vectors++; if (rtr_v_o !== 1'b1) begin miscompares++; $display("FAIL mid_pre_rtr_v: got %b expected 1", rtr_v_o); end
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    vectors++; if (rtr_v_o !== 1'b0) begin miscompares++; $display("FAIL mid_rtr_v: got %b expected 0", rtr_v_o); end
    vectors++; if (ep_v_o !== 3'b000) begin miscompares++; $display("FAIL mid_ep_v: got %b expected 000", ep_v_o); end
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL mid_err: got %b expected 0", err_o); end
    reset_n = 1'b1; rtr_ready_i = 1'b1; ep_v_i = 3'b101;
    ep_data_i[0] = 16'h0D0D; ep_data_i[2] = 16'h0E0E;
    #1;
    vectors++; if (ep_ready_o !== 3'b001) begin miscompares++; $display("FAIL mid_ptr0_grant: got %b expected 001", ep_ready_o); end
    @(negedge clk);
    #1;
    vectors++; if (rtr_data_o !== 16'h0D0D) begin miscompares++; $display("FAIL mid_first_data: got %h expected 0d0d", rtr_data_o); end
    vectors++; if (ep_ready_o !== 3'b100) begin miscompares++; $display("FAIL mid_second_grant: got %b expected 100", ep_ready_o); end
    $display("reset mid-op: rtr_data=%h next grant=%b", rtr_data_o, ep_ready_o);
    ep_v_i = '0;
    repeat (2) @(negedge clk);
  endtask

`ifdef BSG_MANYCORE_LOCAL_MUX_STATS_EN
  task automatic test_stats;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; rtr_ready_i = 1'b1; ep_v_i = 3'b001; ep_data_i[0] = 16'h1234;
    repeat (70000) @(negedge clk);
    ep_v_i = '0;
    #1;
    vectors++; if (ep_tx_count_o[0] !== 16'hFFFF) begin miscompares++; $display("FAIL stats_tx0: got %h expected ffff", ep_tx_count_o[0]); end
    vectors++; if (ep_tx_count_o[1] !== 16'h0000) begin miscompares++; $display("FAIL stats_tx1: got %h expected 0000", ep_tx_count_o[1]); end
    $display("stats: tx0=%h tx1=%h", ep_tx_count_o[0], ep_tx_count_o[1]);
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_fifo_full();
    test_misaddress();
    test_reset_mid();
`ifdef BSG_MANYCORE_LOCAL_MUX_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
